// File: rtl/lcg_checker.sv
// lcg_checker: locks onto a 32-bit LCG word stream and flags/counts mismatches once locked.
// Optional LCG_CHECKER_DEBUG_EN adds exp_data (current prediction) and last_bad (last counted bad word).
module lcg_checker #(
   parameter logic [31:0] A           = 32'd1103515245,
   parameter logic [31:0] C           = 32'd12345,
   parameter int          MOD_BITS    = 31,
   parameter int          LOCK_CNT    = 4,
   parameter int          UNLOCK_ERRS = 3,
   parameter int          ERR_CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [31:0]          in_data,
   input  logic                 err_clr,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count
`ifdef LCG_CHECKER_DEBUG_EN
   ,
   output logic [31:0]          exp_data,
   output logic [31:0]          last_bad
`endif
);

   localparam logic [31:0] MASK = 32'((64'd1 << MOD_BITS) - 64'd1);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_ERRS + 2);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t                 state_q, state_d;
   logic [31:0]            pred_q, pred_d;
   logic [GW-1:0]          good_cnt_q, good_cnt_d;
   logic [BW-1:0]          bad_run_q, bad_run_d;
   logic                   err_pulse_q, err_pulse_d;
   logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
   logic                   err_inc, in_range, match;
   logic [31:0]            f_in, f_pred;
   logic [GW-1:0]          good_inc;
   logic [BW-1:0]          bad_inc;

   function automatic logic [31:0] lcg_f(input logic [31:0] x);
      return (A * x + C) & MASK;
   endfunction

   assign in_range = (in_data & ~MASK) == 32'd0;
   assign match    = in_data == pred_q;
   assign f_in     = lcg_f(in_data);
   assign f_pred   = lcg_f(pred_q);
   assign good_inc = good_cnt_q + GW'(1);
   assign bad_inc  = bad_run_q + BW'(1);

   always_comb begin
      state_d    = state_q;
      pred_d     = pred_q;
      good_cnt_d = good_cnt_q;
      bad_run_d  = bad_run_q;
      err_inc    = 1'b0;
      if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (in_range) begin
                  pred_d     = f_in;
                  good_cnt_d = '0;
                  state_d    = VERIFY;
               end
            end
            VERIFY: begin
               if (match) begin
                  pred_d     = f_in;
                  good_cnt_d = good_inc;
                  if (good_inc == GW'(LOCK_CNT)) begin
                     state_d   = LOCKED;
                     bad_run_d = '0;
                  end
               end else if (in_range) begin
                  pred_d     = f_in;
                  good_cnt_d = '0;
               end else begin
                  state_d = HUNT;
               end
            end
            LOCKED: begin
               if (match) begin
                  pred_d    = f_in;
                  bad_run_d = '0;
               end else begin
                  // free-run the prediction so one corrupted word does not cost lock
                  pred_d    = f_pred;
                  bad_run_d = bad_inc;
                  err_inc   = 1'b1;
                  if (UNLOCK_ERRS != 0 && bad_inc == BW'(UNLOCK_ERRS)) state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
      err_pulse_d = err_inc;
      err_count_d = err_clr ? ERR_CNT_W'(err_inc) :
                    (err_inc && !(&err_count_q)) ? err_count_q + ERR_CNT_W'(1) : err_count_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         pred_q      <= '0;
         good_cnt_q  <= '0;
         bad_run_q   <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         pred_q      <= pred_d;
         good_cnt_q  <= good_cnt_d;
         bad_run_q   <= bad_run_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = state_q == LOCKED;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

`ifdef LCG_CHECKER_DEBUG_EN
   logic [31:0] last_bad_q, last_bad_d;

   always_comb begin
      last_bad_d = err_inc ? in_data : err_clr ? 32'd0 : last_bad_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_bad_q <= '0;
      else        last_bad_q <= last_bad_d;
   end

   assign exp_data = pred_q;
   assign last_bad = last_bad_q;
`endif

endmodule
